change_dispenser: RTL and testbench
===================================

# change_dispenser

Sequences payout of the change amount produced by the vending machine's checkout state into individual coins, one hopper transaction per coin. Keeps a per-denomination coin stock, uses a greedy largest-coin-first algorithm, and handshakes with the coin hopper. Sits between the vending machine's `exchange` output and the physical hopper interface.

## Interface
- `STOCK_W`, 6: width of each per-denomination stock counter; saturates at 2^STOCK_W-1.
- `INIT_STOCK`, 10: stock loaded into every denomination on reset.
- `ACK_TIMEOUT`, 15: cycles `hopper_req` may stay high without `hopper_ack` before abort.
---
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  reset; asynchronous and active-high.
- `start`  in  1  request payout of `amount`; sampled only in IDLE.
- `amount`  in  8  change to pay, in currency units.
- `refill`  in  1  add coins to stock; sampled only in IDLE.
- `refill_sel`  in  2  denomination for refill/hopper: 00=1, 01=5, 10=10, 11=50.
- `refill_cnt`  in  STOCK_W  coins added on refill.
- `hopper_ack`  in  1  hopper has ejected the requested coin.
- `hopper_req`  out  1  coin eject request.
- `hopper_sel`  out  2  denomination to eject; same encoding as `refill_sel`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse: full amount paid.
- `fail_code`  out  2  00 none, 01 insufficient coins, 10 hopper timeout; held until next accepted `start` or reset.
- `remaining`  out  8  amount still unpaid.
- `stock_1`, `stock_5`, `stock_10`, `stock_50`  out  STOCK_W each  current coin stock.

## Operation
- States: IDLE, PICK, DISPENSE, DONE, FAIL. Outputs decode from the registered state. `hopper_req` is high iff DISPENSE; `done` is high iff DONE.
- IDLE, `start`=1: latch `amount` into `remaining` and clear `fail_code`. Go to DONE if `amount`==0, else PICK.
- IDLE, `refill`=1: selected stock += `refill_cnt`, saturating at max. `start` and `refill` in the same cycle are both applied, and PICK sees the updated stock.
- `start`/`refill` outside IDLE are ignored; there is no queueing.
- PICK: choose the largest d in {50,10,5,1} with d <= `remaining` and stock_d > 0. Register `hopper_sel` and go to DISPENSE. If no such d exists, go to FAIL with `fail_code`=01.
- DISPENSE: hold `hopper_req` and `hopper_sel` stable until `hopper_ack`.
  - On `hopper_ack`: stock_d -= 1 and `remaining` -= d. Go to DONE if the new `remaining`==0, else PICK.
  - `hopper_ack` outside DISPENSE is ignored.
- Timeout counter clears on entry to DISPENSE and increments each DISPENSE cycle without ack. When it reaches `ACK_TIMEOUT` with no ack, go to FAIL with `fail_code`=10; stock and `remaining` are unchanged.
- DONE: `done`=1 for one cycle, then IDLE.
- FAIL: one cycle, then IDLE. `remaining` keeps the unpaid amount.
- Arithmetic: 8-bit `remaining`; subtraction never underflows because d <= `remaining` is guaranteed. Stock never decrements below 0; refill saturates.

## Timing
- Reset values: state IDLE, all stocks = `INIT_STOCK`, `remaining`=0, `fail_code`=00; `hopper_req`, `busy`, `done` low; `hopper_sel`=00.
- Reset asserted mid-DISPENSE drops `hopper_req` immediately (asynchronous) and reloads stocks.
- `busy` rises in the first cycle after the `start` edge.
- `amount`=0: `done` is high in cycle 1 after `start`; IDLE in cycle 2.
- Each coin costs 2 cycles (PICK + DISPENSE) when `hopper_ack` is already high in the first DISPENSE cycle. Each extra cycle of ack delay adds one cycle.
- N coins with immediate ack: `done` in cycle 2N+1 after `start`.
- Timeout: FAIL entered `ACK_TIMEOUT` cycles after DISPENSE entry.

## Test plan
- Reset, `start` with `amount`=16, `hopper_ack` tied high -> `hopper_sel` 10,01,00; `done` in cycle 7; stock_10=9, stock_5=9, stock_1=9; `remaining`=0.
- `amount`=0 -> `done` in cycle 1 with no `hopper_req`; stocks unchanged.
- stock_5 and stock_1 drained to 0 (via payouts), then `amount`=7 -> `fail_code`=01, `remaining`=7, no `hopper_req`.
- `amount`=50, `hopper_ack` never asserted -> `hopper_req` high 15 cycles, then `fail_code`=10, `remaining`=50, stock_50=10.
- `refill` of 63 coins (sel 11) with stock_50=10 -> stock_50=63 (saturated). Same `refill` during `busy` -> ignored.
- `amount`=60 with ack delayed 3 cycles per coin, reset asserted during the second DISPENSE -> `hopper_req` low immediately; all stocks=10; state IDLE.

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser: pays out a change amount one coin at a time, greedy
// largest-coin-first, from per-denomination stock, via a req/ack hopper.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   start, amount       begin a payout of amount (accepted only when idle)
//   refill, refill_sel,
//   refill_cnt          add coins to one denomination (accepted only when idle)
//   hopper_ack          hopper has ejected the requested coin
//   hopper_req,
//   hopper_sel          eject request and denomination (00=1,01=5,10=10,11=50)
//   busy, done          not idle / one-cycle payout-complete pulse
//   fail_code           00 none, 01 insufficient coins, 10 hopper timeout
//   remaining           amount still unpaid
//   stock_1..stock_50   current coin stock per denomination
module change_dispenser #(
    parameter int STOCK_W     = 6,
    parameter int INIT_STOCK  = 10,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         amount,
    input  logic               refill,
    input  logic [1:0]         refill_sel,
    input  logic [STOCK_W-1:0] refill_cnt,
    input  logic               hopper_ack,
    output logic               hopper_req,
    output logic [1:0]         hopper_sel,
    output logic               busy,
    output logic               done,
    output logic [1:0]         fail_code,
    output logic [7:0]         remaining,
    output logic [STOCK_W-1:0] stock_1,
    output logic [STOCK_W-1:0] stock_5,
    output logic [STOCK_W-1:0] stock_10,
    output logic [STOCK_W-1:0] stock_50
);

    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PICK,
        S_DISPENSE,
        S_DONE,
        S_FAIL
    } state_t;

    state_t state, state_nxt;

    logic [STOCK_W-1:0] stock_q [4];
    logic [TW-1:0]      to_cnt;

    logic               pick_ok;
    logic [1:0]         pick_sel;
    logic               to_hit;
    logic [7:0]         rem_after;
    logic [STOCK_W:0]   refill_sum;
    logic [STOCK_W-1:0] refill_val;

    function automatic logic [7:0] coin_value(input logic [1:0] sel);
        logic [7:0] v;
        unique case (sel)
            2'b00:   v = 8'd1;
            2'b01:   v = 8'd5;
            2'b10:   v = 8'd10;
            default: v = 8'd50;
        endcase
        return v;
    endfunction

    // Greedy choice: largest coin that fits and is in stock.
    always_comb begin
        pick_ok  = 1'b1;
        pick_sel = 2'b00;
        if (remaining >= 8'd50 && stock_q[3] != '0) begin
            pick_sel = 2'b11;
        end else if (remaining >= 8'd10 && stock_q[2] != '0) begin
            pick_sel = 2'b10;
        end else if (remaining >= 8'd5 && stock_q[1] != '0) begin
            pick_sel = 2'b01;
        end else if (remaining >= 8'd1 && stock_q[0] != '0) begin
            pick_sel = 2'b00;
        end else begin
            pick_ok = 1'b0;
        end
    end

    // Counter holds k in the k-th unacked DISPENSE cycle (0-based), so the
    // abort fires after exactly ACK_TIMEOUT cycles of request.
    assign to_hit    = (to_cnt == TW'(ACK_TIMEOUT - 1));
    assign rem_after = remaining - coin_value(hopper_sel);

    // Saturating refill: carry out of the widened sum means overflow.
    assign refill_sum = {1'b0, stock_q[refill_sel]} + {1'b0, refill_cnt};
    assign refill_val = refill_sum[STOCK_W] ? '1 : refill_sum[STOCK_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (amount == 8'd0) ? S_DONE : S_PICK;
                end
            end
            S_PICK: begin
                state_nxt = pick_ok ? S_DISPENSE : S_FAIL;
            end
            S_DISPENSE: begin
                if (hopper_ack) begin
                    state_nxt = (rem_after == 8'd0) ? S_DONE : S_PICK;
                end else if (to_hit) begin
                    state_nxt = S_FAIL;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            S_FAIL:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                stock_q[i] <= STOCK_W'(INIT_STOCK);
            end
            remaining  <= 8'd0;
            fail_code  <= 2'b00;
            hopper_sel <= 2'b00;
            to_cnt     <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        remaining <= amount;
                        fail_code <= 2'b00;
                    end
                    if (refill) begin
                        stock_q[refill_sel] <= refill_val;
                    end
                end
                S_PICK: begin
                    to_cnt <= '0;
                    if (pick_ok) begin
                        hopper_sel <= pick_sel;
                    end else begin
                        fail_code <= 2'b01;
                    end
                end
                S_DISPENSE: begin
                    if (hopper_ack) begin
                        remaining <= rem_after;
                        if (stock_q[hopper_sel] != '0) begin
                            stock_q[hopper_sel] <=
                                stock_q[hopper_sel] - STOCK_W'(1);
                        end
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                        if (to_hit) begin
                            fail_code <= 2'b10;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign hopper_req = (state == S_DISPENSE);
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);

    assign stock_1  = stock_q[0];
    assign stock_5  = stock_q[1];
    assign stock_10 = stock_q[2];
    assign stock_50 = stock_q[3];

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: table vectors, hand sequences and randomized payouts
// checked against a greedy arithmetic model of the dispenser.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] amount = 8'd0;
    logic       refill = 1'b0;
    logic [1:0] refill_sel = 2'b00;
    logic [5:0] refill_cnt = 6'd0;
    logic       hopper_ack = 1'b0;
    logic       hopper_req;
    logic [1:0] hopper_sel;
    logic       busy;
    logic       done;
    logic [1:0] fail_code;
    logic [7:0] remaining;
    logic [5:0] stock_1, stock_5, stock_10, stock_50;

    change_dispenser #(
        .STOCK_W(6), .INIT_STOCK(10), .ACK_TIMEOUT(15)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .amount(amount),
        .refill(refill), .refill_sel(refill_sel), .refill_cnt(refill_cnt),
        .hopper_ack(hopper_ack), .hopper_req(hopper_req),
        .hopper_sel(hopper_sel), .busy(busy), .done(done),
        .fail_code(fail_code), .remaining(remaining),
        .stock_1(stock_1), .stock_5(stock_5),
        .stock_10(stock_10), .stock_50(stock_50)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Hopper behaviour: ack_delay >= 0 acks in that (0-based) request
    // cycle, -1 never acks, -2 holds ack high permanently.
    int         ack_delay = 0;
    int         req_cnt = 0;
    logic [1:0] sel_log[$];
    logic       mid_rf = 1'b0;

    always @(negedge clk) begin
        if (ack_delay == -2) begin
            hopper_ack = 1'b1;
            if (hopper_req) sel_log.push_back(hopper_sel);
        end else if (hopper_req) begin
            if (ack_delay >= 0 && req_cnt >= ack_delay) begin
                hopper_ack = 1'b1;
                sel_log.push_back(hopper_sel);
            end else begin
                hopper_ack = 1'b0;
            end
            req_cnt++;
        end else begin
            hopper_ack = 1'b0;
            req_cnt = 0;
        end
    end

    task automatic check(input string nm, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Launch one payout; cycle 1 is the first cycle after the start edge.
    task automatic run(input logic [7:0] amt, input int dly,
                       input logic rf, input logic [1:0] rs,
                       input logic [5:0] rc,
                       output int idle_c, output int done_c,
                       output int req_c);
        sel_log.delete();
        ack_delay = dly;
        @(negedge clk);
        start = 1'b1; amount = amt;
        refill = rf; refill_sel = rs; refill_cnt = rc;
        @(negedge clk);
        start = 1'b0; refill = 1'b0;
        idle_c = -1; done_c = -1; req_c = 0;
        for (int c = 1; c <= 2000 && idle_c < 0; c++) begin
            if (c > 1) @(negedge clk);
            if (mid_rf && c == 2) begin
                refill = 1'b1; refill_sel = 2'b00; refill_cnt = 6'd5;
            end
            if (c == 3) refill = 1'b0;
            if (done && done_c < 0) done_c = c;
            if (hopper_req) req_c++;
            if (!busy) idle_c = c;
        end
        if (idle_c < 0) check("run_bound", 0, 1);
    endtask

    typedef struct {
        logic [7:0] amt;
        int         dly;
        int         idle_c;
        int         done_c;
        int         reqc;
        logic [1:0] fc;
        logic [7:0] rem;
        int         ncoin;
        logic [15:0] sels;
        logic [5:0] s1, s5, s10, s50;
    } vec_t;

    vec_t vt[6];
    int   ms[4];
    int   dv[4];
    logic [1:0] expq[$];

    int idle_c, done_c, req_c;

    initial begin
        vt[0] = '{8'd16,  -2, 8,  7,  3,  2'b00, 8'd0,  3, 16'h0006,
                  6'd9,  6'd9,  6'd9,  6'd10};
        vt[1] = '{8'd0,   -2, 2,  1,  0,  2'b00, 8'd0,  0, 16'h0000,
                  6'd10, 6'd10, 6'd10, 6'd10};
        vt[2] = '{8'd50,  -1, 18, -1, 15, 2'b10, 8'd50, 0, 16'h0000,
                  6'd10, 6'd10, 6'd10, 6'd10};
        vt[3] = '{8'd66,  1,  14, 13, 8,  2'b00, 8'd0,  4, 16'h001B,
                  6'd9,  6'd9,  6'd9,  6'd9};
        vt[4] = '{8'd255, 0,  14, 13, 6,  2'b00, 8'd0,  6, 16'h07FF,
                  6'd10, 6'd9,  6'd10, 6'd5};
        vt[5] = '{8'd3,   2,  14, 13, 9,  2'b00, 8'd0,  3, 16'h0000,
                  6'd7,  6'd10, 6'd10, 6'd10};
        dv[0] = 1; dv[1] = 5; dv[2] = 10; dv[3] = 50;

        // Reset state, sampled while reset is still asserted.
        @(negedge clk);
        check("rst_req", hopper_req, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sel", hopper_sel, 0);
        check("rst_rem", remaining, 0);
        check("rst_fc", fail_code, 0);
        check("rst_s1", stock_1, 10);
        check("rst_s50", stock_50, 10);
        reset = 1'b0;

        // Table vectors, each from a fresh reset.
        for (int v = 0; v < 6; v++) begin
            logic [15:0] packed_sel;
            do_reset();
            run(vt[v].amt, vt[v].dly, 1'b0, 2'b00, 6'd0,
                idle_c, done_c, req_c);
            packed_sel = '0;
            foreach (sel_log[i]) begin
                if (i < 8) packed_sel[2*i +: 2] = sel_log[i];
            end
            check($sformatf("v%0d_idle", v), idle_c, vt[v].idle_c);
            check($sformatf("v%0d_done", v), done_c, vt[v].done_c);
            check($sformatf("v%0d_req", v), req_c, vt[v].reqc);
            check($sformatf("v%0d_fc", v), fail_code, vt[v].fc);
            check($sformatf("v%0d_rem", v), remaining, vt[v].rem);
            check($sformatf("v%0d_ncoin", v), sel_log.size(), vt[v].ncoin);
            check($sformatf("v%0d_sels", v), packed_sel, vt[v].sels);
            check($sformatf("v%0d_s1", v), stock_1, vt[v].s1);
            check($sformatf("v%0d_s5", v), stock_5, vt[v].s5);
            check($sformatf("v%0d_s10", v), stock_10, vt[v].s10);
            check($sformatf("v%0d_s50", v), stock_50, vt[v].s50);
        end

        // Drain 5s and 1s with ten payouts of 6, then 7 cannot be paid.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            run(8'd6, 0, 1'b0, 2'b00, 6'd0, idle_c, done_c, req_c);
        end
        check("drain_s5", stock_5, 0);
        check("drain_s1", stock_1, 0);
        run(8'd7, 0, 1'b0, 2'b00, 6'd0, idle_c, done_c, req_c);
        check("insuf_fc", fail_code, 1);
        check("insuf_rem", remaining, 7);
        check("insuf_req", req_c, 0);
        check("insuf_idle", idle_c, 3);
        check("insuf_s10", stock_10, 10);

        // Saturating refill, then a refill while busy is ignored.
        do_reset();
        @(negedge clk);
        refill = 1'b1; refill_sel = 2'b11; refill_cnt = 6'd63;
        @(negedge clk);
        refill = 1'b0;
        check("refill_sat", stock_50, 63);
        mid_rf = 1'b1;
        run(8'd50, 3, 1'b0, 2'b00, 6'd0, idle_c, done_c, req_c);
        mid_rf = 1'b0;
        check("busy_refill_s1", stock_1, 10);
        check("busy_refill_s50", stock_50, 62);
        check("busy_refill_done", done_c, 6);

        // Asynchronous reset in the middle of the second DISPENSE.
        do_reset();
        ack_delay = 3;
        sel_log.delete();
        @(negedge clk);
        start = 1'b1; amount = 8'd60;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_req_before", hopper_req, 1);
        check("mid_s50_before", stock_50, 9);
        reset = 1'b1;
        #1;
        check("mid_req_after", hopper_req, 0);
        check("mid_busy_after", busy, 0);
        check("mid_s50_after", stock_50, 10);
        check("mid_s10_after", stock_10, 10);
        check("mid_rem_after", remaining, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_idle", busy, 0);

        // Randomized payouts against the greedy model.
        do_reset();
        for (int s = 0; s < 4; s++) ms[s] = 10;
        for (int it = 0; it < 40; it++) begin
            logic [7:0] amt;
            int         dly, rem_m, fc_m, cyc, bad;
            logic       rf;
            logic [1:0] rs;
            logic [5:0] rc;
            amt = 8'($urandom_range(0, 255));
            dly = $urandom_range(0, 3);
            rf  = ($urandom_range(0, 3) == 0);
            rs  = 2'($urandom_range(0, 3));
            rc  = 6'($urandom_range(0, 63));
            if (rf) ms[rs] = (ms[rs] + rc > 63) ? 63 : ms[rs] + rc;
            rem_m = amt;
            expq.delete();
            for (int s = 3; s >= 0; s--) begin
                while (rem_m >= dv[s] && ms[s] > 0) begin
                    rem_m -= dv[s];
                    ms[s]--;
                    expq.push_back(2'(s));
                end
            end
            fc_m = (rem_m > 0) ? 1 : 0;
            cyc  = expq.size() * (2 + dly);
            run(amt, dly, rf, rs, rc, idle_c, done_c, req_c);
            bad = -1;
            if (sel_log.size() == expq.size()) begin
                foreach (expq[i]) if (sel_log[i] != expq[i]) bad = i;
            end
            check($sformatf("r%0d_ncoin", it), sel_log.size(), expq.size());
            check($sformatf("r%0d_selidx", it), bad, -1);
            check($sformatf("r%0d_fc", it), fail_code, fc_m);
            check($sformatf("r%0d_rem", it), remaining, rem_m);
            check($sformatf("r%0d_idle", it), idle_c,
                  cyc + (fc_m != 0 ? 3 : 2));
            check($sformatf("r%0d_done", it), done_c,
                  (fc_m != 0) ? -1 : cyc + 1);
            check($sformatf("r%0d_s1", it), stock_1, ms[0]);
            check($sformatf("r%0d_s5", it), stock_5, ms[1]);
            check($sformatf("r%0d_s10", it), stock_10, ms[2]);
            check($sformatf("r%0d_s50", it), stock_50, ms[3]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
